// File: rtl/simon_seq_gen_pkg.sv
// Shared types and constants for the Simon sequence generator.
package simon_pkg;
  localparam int          DIGIT_W    = 4;
  localparam int          NUM_DIGITS = 3;
  localparam logic [15:0] LFSR_TAPS  = 16'hB400;

  typedef enum logic [2:0] {IDLE, DRAW0, DRAW1, DRAW2, COMMIT} gen_state_t;
  typedef logic [DIGIT_W-1:0] digit_t;
endpackage

// File: rtl/simon_seq_gen_if.sv
// Request/response bundle between the game controller and the generator.
interface simon_seq_gen_if;
  import simon_pkg::*;
  logic                          en;
  logic [NUM_DIGITS*DIGIT_W-1:0] idx;
  logic                          lsb;
  logic                          valid;
  logic                          busy;

  modport master (output en, input idx, lsb, valid, busy);
  modport slave  (input en, output idx, lsb, valid, busy);
endinterface

// File: rtl/simon_seq_gen_lfsr16.sv
// Free-running 16-bit Galois LFSR (right shift); a zero seed would lock up, so it becomes 1.
module lfsr16
  import simon_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] seed,
  output logic [15:0] q
);
  // Advance every cycle regardless of what the consumer is doing.
  always_ff @(posedge clk) begin
    if (rst) q <= (seed == 16'h0000) ? 16'h0001 : seed;
    else     q <= {1'b0, q[15:1]} ^ (q[0] ? LFSR_TAPS : 16'h0000);
  end
endmodule

// File: rtl/simon_seq_gen.sv
// Draws three distinct 4-bit digits plus a Simon-says flag per request.
// Duplicate candidates are retried up to MAX_RETRY times, then replaced by
// the smallest digit not yet taken so a draw always terminates.
module simon_seq_gen
  import simon_pkg::*;
#(
  parameter logic [15:0] SEED        = 16'hACE1,
  parameter logic [4:0]  SAYS_THRESH = 5'd11,
  parameter int          MAX_RETRY   = 3
) (
  input  logic           clk,
  input  logic           rst,
  simon_seq_gen_if.slave bus
);
  localparam logic [2:0] RETRY_LIM = 3'(MAX_RETRY);

  gen_state_t  state;
  logic [15:0] lfsr;
  digit_t      s0, s1, cand, fallback, pick;
  logic [2:0]  retry;
  logic [15:0] used;
  logic        dup, says;

  lfsr16 u_lfsr (.clk(clk), .rst(rst), .seed(SEED), .q(lfsr));

  // A maximal-length Galois LFSR can never fall into the all-zero state.
  a_lfsr_nonzero: assert property (@(posedge clk) disable iff (rst) lfsr != 16'h0000);

  // Candidate screening and lowest-free-digit fallback for the current draw stage.
  always_comb begin
    cand = lfsr[3:0];
    says = ({1'b0, lfsr[7:4]} < SAYS_THRESH);
    used = '0;
    used[s0] = 1'b1;
    if (state == DRAW2) used[s1] = 1'b1;
    dup = (cand == s0) || ((state == DRAW2) && (cand == s1));
    fallback = '0;
    for (int i = 15; i >= 0; i--)
      if (!used[i]) fallback = digit_t'(i);
    pick = dup ? fallback : cand;
  end

  // Draw sequencer; idx/lsb/valid land together on the edge leaving DRAW2,
  // so valid is high during COMMIT and idx holds its old value until then.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      s0        <= '0;
      s1        <= '0;
      retry     <= '0;
      bus.idx   <= '0;
      bus.lsb   <= 1'b0;
      bus.valid <= 1'b0;
      bus.busy  <= 1'b0;
    end else begin
      bus.valid <= 1'b0;
      case (state)
        IDLE: if (bus.en) begin
          state    <= DRAW0;
          retry    <= '0;
          bus.busy <= 1'b1;
        end
        DRAW0: begin
          s0    <= cand;
          state <= DRAW1;
        end
        DRAW1: begin
          if (!dup || retry >= RETRY_LIM) begin
            s1    <= pick;
            retry <= '0;
            state <= DRAW2;
          end else begin
            retry <= retry + 3'd1;
          end
        end
        DRAW2: begin
          if (!dup || retry >= RETRY_LIM) begin
            bus.idx   <= {pick, s1, s0};
            bus.lsb   <= says;
            bus.valid <= 1'b1;
            retry     <= '0;
            state     <= COMMIT;
          end else begin
            retry <= retry + 3'd1;
          end
        end
        COMMIT: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/simon_seq_gen.md
Name: simon_seq_gen

Overview:
Upstream sequence source for the Simon Says game controller. On a one-cycle request it draws three mutually distinct 4-bit digits plus a "Simon says" flag from a free-running 16-bit LFSR and presents them as a packed 12-bit combination. The controller pulses the request on leaving READY and consumes the idx and lsb outputs during GAME and EVAL. The block replaces the file-read source with a synthesizable generator that does not repeat digits.

Parameters:
SEED, 16'hACE1, LFSR reset value; 16'h0000 is replaced by 16'h0001.
SAYS_THRESH, 5'd11, lsb=1 when the drawn nibble < SAYS_THRESH; 0 forces lsb=0, 16 forces lsb=1.
MAX_RETRY, 3, failed duplicate draws per digit before the deterministic fallback (0..7).

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
en  input  1  request pulse; a new combination is drawn
idx  output  12  {digit2, digit1, digit0}, 4 bits each, all distinct
lsb  output  1  Simon-says flag for this combination
valid  output  1  one-cycle pulse when idx/lsb update
busy  output  1  high while a draw is in progress

Behaviour:
- Reset: one clk edge with rst=1 gives state=IDLE, lfsr=SEED (or 1), idx=0, lsb=0, valid=0, busy=0, staging regs=0, retry count=0. Reset mid-draw aborts the draw; idx is not updated.
- LFSR: 16-bit Galois, taps 16'hB400, right shift. Advances every clk, including IDLE and while busy. Never reaches 0.
- Candidate = lfsr[3:0] of the current cycle. Says nibble = lfsr[7:4], sampled in DRAW2.
- States:
  - IDLE: busy=0. en=1 -> DRAW0, retry count cleared.
  - DRAW0: latch the candidate into s0 unconditionally -> DRAW1.
  - DRAW1: if candidate != s0, latch it into s1 -> DRAW2, retry cleared. Else if retry < MAX_RETRY, retry+1 and stay. Else latch the fallback -> DRAW2.
  - DRAW2: same rule against s0 and s1. On latch, also compute lsb_next = (says nibble < SAYS_THRESH) -> COMMIT.
  - COMMIT: idx <= {s2,s1,s0}, lsb <= lsb_next, valid=1 for exactly this one cycle -> IDLE.
- Fallback value: the smallest value 0..15 not equal to any digit already latched. This is a combinational priority pick.
- busy=1 in DRAW0, DRAW1, DRAW2 and COMMIT.
- Latency: en sampled at edge t; valid is high in the cycle after edge t+3 and idx is updated at that edge. Minimum latency is 4 cycles. Maximum latency is 4 + 2*MAX_RETRY cycles.
- en while busy=1 is ignored and not queued. en in the COMMIT cycle is also ignored.
- idx and lsb hold their last committed values between commits and throughout a draw. The controller may display them during the next request.
- valid and en are independent. The block never asserts valid without a preceding accepted en.

Decomposition:
- Package simon_pkg:
  - gen_state_t enum {IDLE, DRAW0, DRAW1, DRAW2, COMMIT}, 3 bits
  - LFSR_TAPS = 16'hB400
  - DIGIT_W = 4
  - NUM_DIGITS = 3
- Sub-module lfsr16 (clk, rst, seed, q[15:0]): free-running Galois LFSR with zero-seed guard.
- The fallback picker and the state machine stay in simon_seq_gen.

Test Plan:
- Reset: hold rst 2 cycles, release -> idx=12'h000, lsb=0, valid=0, busy=0. With SEED=0, internal lfsr=16'h0001 after reset.
- Latency: single en pulse when the model predicts no duplicate -> busy rises next cycle; valid is high exactly 4 cycles after en. idx matches the reference-model nibbles and digits are distinct.
- Request while busy: pulse en, then pulse en again 2 cycles later -> exactly one valid pulse. idx keeps the old value until the commit edge.
- Fallback: MAX_RETRY=0, force lfsr (hierarchical deposit) so DRAW1 sees candidate == s0 == 4'h0 -> s1=4'h1. If DRAW2 then sees 4'h1, s2=4'h2, and idx=12'h210.
- Flag bias: SAYS_THRESH=16 over 200 requests -> lsb=1 always. SAYS_THRESH=0 -> lsb=0 always. Default over 1000 requests -> lsb within 11/16 ±5%.
- Reset mid-draw: assert rst in DRAW1 -> no valid pulse, idx=0, state IDLE next cycle. A new en then completes normally in 4 cycles.
